// File: rtl/multiplier_datapath.sv
// Shift-and-add multiplier datapath.
// Responds to a Moore controller: load captures the operands, each accepted
// shift step adds the shifted multiplicand into the accumulator when the
// current multiplier LSB is set. After WORD_LENGTH accepted steps the
// accumulator holds the full unsigned product and FinishShift stays high
// until the next load, synchronous clear or reset.
module multiplier_datapath #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     load,
  input  logic                     shift,
  input  logic                     sync_reset,
  input  logic                     enable,
  input  logic [WORD_LENGTH-1:0]   Multiplicand,
  input  logic [WORD_LENGTH-1:0]   Multiplier,
  output logic                     FinishLoad,
  output logic                     FinishShift,
  output logic [2*WORD_LENGTH-1:0] Product
);

  // The counter must be able to hold WORD_LENGTH itself, hence the extra bit.
  localparam int CW = $clog2(WORD_LENGTH) + 1;
  localparam logic [CW-1:0] STEPS = CW'(WORD_LENGTH);

  logic [2*WORD_LENGTH-1:0] mcand_q, mcand_d;
  logic [WORD_LENGTH-1:0]   mplier_q, mplier_d;
  logic [2*WORD_LENGTH-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     fload_q, fload_d;
  logic                     step_ok;

  // A step is accepted only while enabled and not yet complete; once the
  // counter reaches WORD_LENGTH further shifts are ignored (no wrap).
  assign step_ok = shift && enable && (cnt_q < STEPS);

  // Next-state selection: synchronous clear, then load, then shift step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fload_d  = fload_q;
    if (!sync_reset) begin
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
      cnt_d    = '0;
      fload_d  = 1'b0;
    end else if (load) begin
      mcand_d  = {{WORD_LENGTH{1'b0}}, Multiplicand};
      mplier_d = Multiplier;
      acc_d    = '0;
      cnt_d    = '0;
      fload_d  = 1'b1;
    end else if (step_ok) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      fload_d  = 1'b0;
    end
  end

  // Datapath registers with asynchronous clear on Reset low.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      fload_q  <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fload_q  <= fload_d;
    end
  end

  // FinishShift is decoded from the counter so it clears with every path
  // that clears the counter (load, sync clear, Reset).
  assign FinishShift = (cnt_q == STEPS);
  assign FinishLoad  = fload_q;
  assign Product     = acc_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// Scoreboard bench for multiplier_datapath (WORD_LENGTH = 8).
// Stimulus pushes the expected post-edge outputs tagged with the cycle they
// belong to; a monitor on the falling edge pops and compares them.
module tb_multiplier_datapath;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           clk_en = 1'b0;
  logic           Reset, load, shift, sync_reset, enable;
  logic [W-1:0]   Multiplicand, Multiplier;
  logic           FinishLoad, FinishShift;
  logic [2*W-1:0] Product;

  int checks = 0;
  int failures = 0;
  int unsigned cyc_cnt = 0;

  typedef struct {
    int unsigned    cyc;
    logic [2*W-1:0] prod;
    logic           fl;
    logic           fs;
    string          name;
  } exp_t;

  exp_t exp_q[$];

  multiplier_datapath #(.WORD_LENGTH(W)) dut (
    .clk(clk),
    .Reset(Reset),
    .load(load),
    .shift(shift),
    .sync_reset(sync_reset),
    .enable(enable),
    .Multiplicand(Multiplicand),
    .Multiplier(Multiplier),
    .FinishLoad(FinishLoad),
    .FinishShift(FinishShift),
    .Product(Product)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Product after k accepted steps: multiplicand times the low k multiplier bits.
  function automatic logic [2*W-1:0] part(input int av, input int bv, input int k);
    int mask;
    mask = (1 << k) - 1;
    return (2*W)'(av * (bv & mask));
  endfunction

  // Monitor: compare every expectation due at the edge just taken.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
      e = exp_q.pop_front();
      chk({e.name, ".Product"}, 32'(Product), 32'(e.prod));
      chk({e.name, ".FinishLoad"}, 32'(FinishLoad), 32'(e.fl));
      chk({e.name, ".FinishShift"}, 32'(FinishShift), 32'(e.fs));
    end
  end

  // Drive one cycle of commands and record what must be visible after the edge.
  task automatic drive(input logic ld, input logic sh, input logic sr_n, input logic en,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] ep, input logic efl, input logic efs,
                       input string nm);
    exp_t e;
    load = ld;
    shift = sh;
    sync_reset = sr_n;
    enable = en;
    Multiplicand = av;
    Multiplier = bv;
    e.cyc = cyc_cnt + 1;
    e.prod = ep;
    e.fl = efl;
    e.fs = efs;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    load = 1'b0;
    shift = 1'b0;
    sync_reset = 1'b1;
    enable = 1'b0;
    Multiplicand = 8'd77;
    Multiplier = 8'd55;
    #2;
    // Reset with no clock running.
    Reset = 1'b0;
    load = 1'b1;
    shift = 1'b1;
    enable = 1'b1;
    #20;
    chk("rst_noclk.Product", 32'(Product), 32'd0);
    chk("rst_noclk.FinishLoad", 32'(FinishLoad), 32'd0);
    chk("rst_noclk.FinishShift", 32'(FinishShift), 32'd0);
    load = 1'b0;
    shift = 1'b0;
    enable = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    drive(0, 0, 1, 0, 8'd0, 8'd0, 16'd0, 0, 0, "idle_after_rst");

    // Basic 13 x 11; operand inputs wiggle during shifts and must be ignored.
    drive(1, 0, 1, 0, 8'd13, 8'd11, 16'd0, 1, 0, "load13x11");
    for (int k = 1; k <= 8; k++)
      drive(0, 1, 1, 1, 8'd200, 8'(k * 37), part(13, 11, k), 0, k == 8, "mul13x11");
    chk("mul13x11.final", 32'(Product), 32'd143);

    // Maximum operands.
    drive(1, 0, 1, 1, 8'd255, 8'd255, 16'd0, 1, 0, "load255");
    for (int k = 1; k <= 8; k++)
      drive(0, 1, 1, 1, 8'd0, 8'd0, part(255, 255, k), 0, k == 8, "mul255");
    chk("mul255.final", 32'(Product), 32'd65025);

    // Gated shifts and shifts beyond completion.
    drive(1, 0, 1, 1, 8'd13, 8'd11, 16'd0, 1, 0, "gate.load");
    drive(0, 1, 1, 0, 8'd13, 8'd11, 16'd0, 1, 0, "gate.en0_after_load");
    for (int k = 1; k <= 2; k++)
      drive(0, 1, 1, 1, 8'd13, 8'd11, part(13, 11, k), 0, 0, "gate.shift");
    for (int i = 0; i < 3; i++)
      drive(0, 1, 1, 0, 8'd13, 8'd11, 16'd39, 0, 0, "gate.frozen");
    for (int k = 3; k <= 8; k++)
      drive(0, 1, 1, 1, 8'd13, 8'd11, part(13, 11, k), 0, k == 8, "gate.shift");
    for (int i = 0; i < 4; i++)
      drive(0, 1, 1, 1, 8'd99, 8'd99, 16'd143, 0, 1, "gate.extra");
    drive(0, 0, 1, 1, 8'd99, 8'd99, 16'd143, 0, 1, "gate.hold");

    // Synchronous clear priority, then load-over-shift priority.
    drive(1, 0, 1, 1, 8'd13, 8'd11, 16'd0, 1, 0, "sync.load");
    for (int k = 1; k <= 3; k++)
      drive(0, 1, 1, 1, 8'd13, 8'd11, part(13, 11, k), 0, 0, "sync.shift");
    drive(1, 1, 0, 1, 8'd13, 8'd11, 16'd0, 0, 0, "sync.clear");
    drive(1, 1, 1, 1, 8'd6, 8'd7, 16'd0, 1, 0, "prio.load_over_shift");
    for (int k = 1; k <= 8; k++)
      drive(0, 1, 1, 1, 8'd6, 8'd7, part(6, 7, k), 0, k == 8, "prio.mul6x7");
    chk("prio.final", 32'(Product), 32'd42);

    // Asynchronous abort between clock edges.
    drive(1, 0, 1, 1, 8'd13, 8'd11, 16'd0, 1, 0, "abort.load");
    for (int k = 1; k <= 4; k++)
      drive(0, 1, 1, 1, 8'd13, 8'd11, part(13, 11, k), 0, 0, "abort.shift");
    #5;
    Reset = 1'b0;
    #1;
    chk("abort.Product", 32'(Product), 32'd0);
    chk("abort.FinishLoad", 32'(FinishLoad), 32'd0);
    chk("abort.FinishShift", 32'(FinishShift), 32'd0);
    @(posedge clk);
    #1;
    drive(1, 1, 1, 1, 8'd13, 8'd11, 16'd0, 0, 0, "abort.held_low");
    Reset = 1'b1;
    drive(0, 0, 1, 1, 8'd13, 8'd11, 16'd0, 0, 0, "abort.idle");
    for (int i = 0; i < 3; i++)
      drive(0, 1, 1, 1, 8'd13, 8'd11, 16'd0, 0, 0, "abort.no_load");
    drive(1, 0, 1, 1, 8'd6, 8'd7, 16'd0, 1, 0, "abort.reload");
    for (int k = 1; k <= 8; k++)
      drive(0, 1, 1, 1, 8'd0, 8'd0, part(6, 7, k), 0, k == 8, "abort.mul6x7");

    drive(0, 0, 1, 0, 8'd0, 8'd0, 16'd42, 0, 1, "end.hold");
    repeat (2) @(posedge clk);
    #6;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
